// File: rtl/mux_nto1_stream_if.sv
// Stream bundle for mux_nto1_stream: per-channel valid/ready inputs, one registered output,
// plus mode/select control. The master drives channels and control; the slave is the mux.
interface mux_nto1_stream_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SELW     = 2
);
  logic                      mode;
  logic [SELW-1:0]           sel;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [SELW-1:0]           out_ch;
  logic                      sel_err;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_ch, sel_err
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_ch, sel_err
  );
endinterface

// File: rtl/mux_nto1_stream.sv
// Registered N-to-1 stream mux: manual select or round-robin arbitration, one-word output
// register with valid/ready, and a one-cycle pulse for out-of-range manual selects.
module mux_nto1_stream #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SELW     = 2
) (
    input logic               clk_i,
    input logic               rst_i,
    mux_nto1_stream_if.slave  bus
);

    logic [WIDTH-1:0]    out_data_q;
    logic                out_valid_q;
    logic [SELW-1:0]     out_ch_q;
    logic                sel_err_q;
    logic [SELW-1:0]     rr_last_q;

    logic                load;
    logic                sel_ok;
    logic                sel_err_d;
    logic                grant_vld;
    logic [SELW-1:0]     grant_idx;
    logic [WIDTH-1:0]    grant_data;
    logic [CHANNELS-1:0] in_ready_d;
    logic [CHANNELS-1:0] vshift;
    logic [31:0]         rr_idx;

    always_comb begin
        load       = !out_valid_q || bus.out_ready;
        sel_ok     = 32'(bus.sel) < CHANNELS;
        sel_err_d  = !bus.mode && !sel_ok;
        grant_vld  = 1'b0;
        grant_idx  = '0;
        vshift     = '0;
        rr_idx     = '0;
        in_ready_d = '0;
        grant_data = '0;

        if (bus.mode) begin
            // Search from rr_last+1 onward, wrapping; first valid channel wins.
            for (int unsigned i = 1; i <= CHANNELS; i++) begin
                rr_idx = (32'(rr_last_q) + i) % CHANNELS;
                vshift = bus.in_valid >> rr_idx;
                if (!grant_vld && vshift[0]) begin
                    grant_vld = 1'b1;
                    grant_idx = SELW'(rr_idx);
                end
            end
        end else if (sel_ok) begin
            vshift    = bus.in_valid >> bus.sel;
            grant_vld = vshift[0];
            grant_idx = bus.sel;
        end

        grant_vld = grant_vld && load && !rst_i;

        for (int unsigned j = 0; j < CHANNELS; j++) begin
            if (grant_idx == SELW'(j)) begin
                in_ready_d[j] = grant_vld;
                grant_data    = bus.in_data[j*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            sel_err_q   <= 1'b0;
            rr_last_q   <= SELW'(CHANNELS - 1);
        end else begin
            sel_err_q <= sel_err_d;
            if (load) begin
                out_valid_q <= grant_vld;
                if (grant_vld) begin
                    out_data_q <= grant_data;
                    out_ch_q   <= grant_idx;
                    if (bus.mode) begin
                        rr_last_q <= grant_idx;
                    end
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_d;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.sel_err   = sel_err_q;

endmodule

// File: doc/mux_nto1_stream.md
# mux_nto1_stream

Parametrised, registered N-to-1 data multiplexer with a valid/ready stream interface on every channel and on the output. It replaces the fixed 8-bit, 3-data-input combinational mux in the datapath. The output is held in a register, so it never drives X. Channel choice is either an externally supplied select or an internal round-robin arbiter. Out-of-range selects are flagged rather than left undefined.

## Interface
Parameters:
- WIDTH, 8, data width per channel
- CHANNELS, 4, number of input channels (2..16)
- SELW, 2, select width; must satisfy 2**SELW >= CHANNELS

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- mode  in  1  0 = manual select, 1 = round-robin
- sel  in  SELW  channel index in manual mode; ignored in round-robin mode
- in_data  in  CHANNELS*WIDTH  flattened inputs; channel i at [i*WIDTH +: WIDTH]
- in_valid  in  CHANNELS  per-channel data valid
- in_ready  out  CHANNELS  per-channel accept strobe; combinational, one-hot or zero
- out_data  out  WIDTH  registered selected data
- out_valid  out  1  out_data holds an unconsumed word
- out_ready  in  1  downstream accepts out_data
- out_ch  out  SELW  index of the channel that supplied out_data
- sel_err  out  1  registered one-cycle pulse for a manual select >= CHANNELS

## Operation
- Reset values: out_data = 0, out_valid = 0, out_ch = 0, sel_err = 0, rr_last = CHANNELS-1. The first round-robin search therefore starts at channel 0.
- load = !out_valid || out_ready. The output stage accepts a new word only when load is high.
- Manual mode (mode = 0):
  - Candidate is sel.
  - If sel >= CHANNELS: no grant, and sel_err is set to 1 on the next edge. The output register is left unchanged.
  - Otherwise the grant goes to sel when in_valid[sel] && load.
- Round-robin mode (mode = 1):
  - Search starts at rr_last+1, wraps modulo CHANNELS, and takes the first channel with in_valid set.
  - The grant is given when load is high.
  - On a grant, rr_last is updated to the granted index.
  - rr_last is not updated in manual mode.
- Grant: in_ready[g] = 1 for the granted channel only; every other in_ready bit is 0 that cycle.
- Next edge after a grant:
  - out_data <= in_data[g]
  - out_ch <= g
  - out_valid <= 1
- Load with no grant: out_valid <= 0. out_data and out_ch keep their values.
- Stall (out_valid && !out_ready): all in_ready bits are 0, and out_data, out_ch and out_valid are held stable.
- sel_err is high for exactly one cycle per offending cycle. It is independent of load and of in_valid.
- Mode change takes effect the same cycle; there is no flush. A word already in the output register is unaffected.
- Reset asserted mid-transfer:
  - All outputs go immediately to their reset values, without waiting for a clock edge.
  - The pending word is dropped.
  - in_ready goes to 0 while reset is high.

## Timing
- Latency: 1 cycle from the in_valid/in_ready handshake to out_valid.
- Throughput: 1 word per cycle while out_ready is held high.
- in_ready depends combinationally on in_valid, sel, mode, out_valid and out_ready. No path exists from in_data to any in_ready bit.
- Every output except in_ready is a flop output.

## Test plan
- Reset, then manual mode with CHANNELS=3, WIDTH=8, in_data = {15, 10, 5}, all valid, out_ready = 1. Step sel through 0, 1, 2 -> out_data is 5, 10, 15 one cycle after each select, with out_ch = 0, 1, 2 and in_ready = 001, 010, 100.
- Same setup with sel = 3 -> in_ready = 000, sel_err pulses for one cycle, out_valid = 0, out_data keeps 15 (never X).
- Round-robin mode, CHANNELS=4, all four valid, out_ready = 1 -> out_ch sequence 0, 1, 2, 3, 0. Then with in_valid = 1010 -> sequence 1, 3, 1, 3.
- Backpressure: out_ready = 0 for 3 cycles with a word of 0xA5 held -> out_data stays 0xA5, out_valid stays 1, in_ready = 0. When out_ready rises, the next word is loaded on the following edge.
- Assert reset asynchronously between clock edges while out_valid = 1 -> out_valid, out_data and out_ch go to 0 before the next edge. After release, round-robin grants channel 0 first.
- No inputs valid, out_ready = 1 -> out_valid falls one cycle after the last word is consumed, and in_ready stays 000.
